// File: rtl/instruction_stream_loader.sv
// Byte-to-word loader: packs UART bytes MSB-first into words and writes them to instruction memory.
// Optional build macro LOADER_CHECKSUM_EN adds a running checksum output of written words.
module instruction_stream_loader #(
    parameter int unsigned             WORD_WIDTH     = 32,
    parameter int unsigned             ADDR_WIDTH     = 12,
    parameter logic [WORD_WIDTH-1:0]   TOGGLE_WORD    = '1,
    parameter int unsigned             IDLE_TIMEOUT   = 1024,
    parameter int unsigned             IDLE_CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_enable,
    input  logic [7:0]              received_data,
    output logic                    in_execution,
    output logic                    write_enable,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [WORD_WIDTH-1:0]   write_data,
    output logic [ADDR_WIDTH:0]     word_count,
    output logic                    overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WORD_WIDTH-1:0]   checksum
`endif
);

    localparam int unsigned BYTES = WORD_WIDTH / 8;
    localparam int unsigned PTR_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH+1:0] DEPTH = {2'b01, {ADDR_WIDTH{1'b0}}};
    localparam bit IDLE_EN = (IDLE_TIMEOUT > 0);
    localparam logic [IDLE_CNT_WIDTH-1:0] IDLE_LAST =
        IDLE_EN ? IDLE_CNT_WIDTH'(IDLE_TIMEOUT - 1) : '0;

    typedef enum logic {
        MODE_LOAD = 1'b0,
        MODE_EXEC = 1'b1
    } mode_t;

    mode_t                     mode_q, mode_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [WORD_WIDTH-1:0]     buf_q, buf_d;
    logic [IDLE_CNT_WIDTH-1:0] idle_q, idle_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [WORD_WIDTH-1:0]     data_q, data_d;
    logic [ADDR_WIDTH:0]       count_q, count_d;
    logic                      ovf_q, ovf_d;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]     sum_q, sum_d;
`endif

    logic [WORD_WIDTH-1:0]     word_c;
    logic                      last_c;
    logic                      full_c;

    // Next-state and datapath decisions for one cycle
    always_comb begin
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        buf_d   = buf_q;
        idle_d  = idle_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        word_c = (buf_q << 8) | WORD_WIDTH'(received_data);
        last_c = input_enable && (ptr_q == PTR_LAST);
        // A pulse in flight is already committed, so it counts toward fullness
        full_c = ({1'b0, count_q} + {{(ADDR_WIDTH + 1){1'b0}}, we_q}) == DEPTH;

        if (we_q) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end

        if (input_enable) begin
            idle_d = '0;
            if (last_c) begin
                ptr_d = '0;
                buf_d = '0;
                if (word_c == TOGGLE_WORD) begin
                    mode_d = (mode_q == MODE_LOAD) ? MODE_EXEC : MODE_LOAD;
                    if (mode_q == MODE_EXEC) begin
                        addr_d  = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end else if (mode_q == MODE_LOAD) begin
                    if (full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        data_d = word_c;
`ifdef LOADER_CHECKSUM_EN
                        sum_d  = sum_q + word_c;
`endif
                    end
                end
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
                buf_d = word_c;
            end
        end else if (ptr_q == '0) begin
            idle_d = '0;
        end else if (IDLE_EN) begin
            // Stalled partial word: drop it so the stream resynchronises
            if (idle_q == IDLE_LAST) begin
                ptr_d  = '0;
                buf_d  = '0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + IDLE_CNT_WIDTH'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_LOAD;
            ptr_q   <= '0;
            buf_q   <= '0;
            idle_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            buf_q   <= buf_d;
            idle_q  <= idle_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign in_execution = (mode_q == MODE_EXEC);
    assign write_enable = we_q;
    assign write_addr   = addr_q;
    assign write_data   = data_q;
    assign word_count   = count_q;
    assign overflow     = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum     = sum_q;
`endif

endmodule
